// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with held grants; define ARB_TIMEOUT_EN to enable timeout preemption
module rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win, j;
  logic [N-1:0] cand;
  logic found, tmo, take;
  assign cand = req & ~gnt;
  always_comb begin
    win = '0;
    found = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      if (cand[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign tmo = state == OWNED && req[gnt_id] && |cand && hold_cnt == 8'(MAX_HOLD - 1);
  always_ff @(posedge clk)
    if (!rst_n) hold_cnt <= '0;
    else if (take) hold_cnt <= '0;
    else if (state == OWNED && hold_cnt != 8'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + 8'd1;
`else
  assign tmo = 1'b0;
`endif
  assign take = found && (state == IDLE || !req[gnt_id] || tmo);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      preempt <= 1'b0;
      ptr <= '0;
    end else begin
      preempt <= tmo;
      if (take) begin
        state <= OWNED;
        gnt <= N'(1) << win;
        gnt_id <= win;
        gnt_valid <= 1'b1;
        ptr <= win == IDW'(N - 1) ? '0 : win + IDW'(1);
      end else if (state == OWNED && !req[gnt_id]) begin
        state <= IDLE;
        gnt <= '0;
        gnt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed vector table plus timeout sequence for rr_arbiter
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid, preempt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_valid(gnt_valid), .preempt(preempt)
  );
  typedef struct packed {
    logic       rn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;
  vec_t vt [29];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step(input logic rn, input logic [3:0] r);
    rst_n = rn;
    req = r;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eid, input logic ep);
    chk({tag, " gnt"}, int'(gnt), int'(eg));
    chk({tag, " gnt_valid"}, int'(gnt_valid), int'(|eg));
    chk({tag, " preempt"}, int'(preempt), int'(ep));
    if (eg != 4'b0000) chk({tag, " gnt_id"}, int'(gnt_id), int'(eid));
  endtask
  initial begin
    vt[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0};
    vt[2]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0};
    vt[3]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0};
    vt[4]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0};
    vt[5]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0};
    vt[6]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0};
    vt[7]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b0};
    vt[8]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0};
    vt[9]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b0};
    vt[10] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0};
    vt[11] = '{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b0};
    vt[12] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0};
    vt[13] = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b0};
    vt[14] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[15] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};
    vt[16] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};
    vt[17] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};
    vt[18] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[19] = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0};
    vt[20] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[21] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};
    vt[22] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vt[23] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0};
    vt[24] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[25] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0};
    vt[26] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vt[27] = '{1'b1, 4'b1001, 4'b0001, 2'd0, 1'b0};
    vt[28] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    for (int i = 0; i < 29; i++) begin
      step(vt[i].rn, vt[i].req);
      chk_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].id, vt[i].pre);
    end
    // owner 0 holds forever; requester 1 joins two cycles into the grant
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i < 2 ? 4'b0001 : 4'b0011);
      chk_out($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
`ifdef ARB_TIMEOUT_EN
    step(1'b1, 4'b0011);
    chk_out("timeout", 4'b0010, 2'd1, 1'b1);
    step(1'b1, 4'b0011);
    chk_out("after_timeout", 4'b0010, 2'd1, 1'b0);
`else
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0011);
      chk_out($sformatf("no_timeout%0d", i), 4'b0001, 2'd0, 1'b0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. a downstream bus or engine slot) among N requesters.
- Owns a sequential grant: one requester holds the grant until it releases.
- Issues a registered one-hot grant plus an encoded grant index for the datapath mux.
- Rotating priority guarantees no requester starves.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IDW, $clog2(N), width of gnt_id; derived, not overridden.
- MAX_HOLD, 8, maximum cycles one owner may hold the grant while others wait. Used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- req  input  N  request vector; req[i]=1 means requester i wants the resource or is still using it.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  IDW  index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  1 when any grant is held (equals |gnt).
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout. Always 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at an edge): gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. Reset overrides everything, including mid-grant; gnt drops at that same edge.
- State machine: IDLE and OWNED.
- Selection:
  - Search req starting at index ptr, ascending with wrap N-1 -> 0; the first set bit wins.
  - ptr=0 gives fixed order 0 > 1 > ... > N-1.
- IDLE:
  - If |req=1, grant the winner at the next edge (1-cycle latency from req to gnt) and go to OWNED.
  - On each grant: ptr <= winner+1 (mod N), hold_cnt <= 0.
- OWNED:
  - While req[owner]=1: hold gnt and gnt_id stable and increment hold_cnt.
  - Release is req[owner]=0. At that edge:
    - If other requests are pending, grant the next winner directly, with no idle bubble (back-to-back ownership).
    - Otherwise clear gnt and go to IDLE.
  - Requests from non-owners never affect gnt while the owner holds.
  - A requester asserting in the same cycle as the owner releases is eligible at that edge.
- The released owner is lowest priority next round because ptr has already moved past it. It can win again only if no other request is pending.
- All outputs are registered; no combinational path from req to gnt.
- gnt is always zero or one-hot; gnt_id == index of the set bit in gnt.
- Owner of index N-1 sets ptr to 0 (wrap).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt reaches MAX_HOLD-1 while the owner still requests and at least one other req bit is set, the grant moves at the next edge to the next winner. The search excludes the current owner.
  - preempt pulses 1 for that one cycle (coincident with the new gnt).
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Undefined: hold_cnt and timeout logic are absent; the owner holds indefinitely; preempt is tied to 0.

Test Plan:
- Reset priority: after reset, req=4'b1010 -> next cycle gnt=4'b0010, gnt_id=1, gnt_valid=1. Drop req[1] -> next cycle gnt=4'b1000, gnt_id=3.
- Rotation fairness: all four req held high; each owner drops its req for one cycle after 2 cycles of grant -> grant order is 0,1,2,3,0, with no gnt=0 cycle between owners.
- Idle: a single pulse on req[2] for 3 cycles, then req=0 -> gnt=4'b0100 for 3 cycles, then gnt=0 and gnt_valid=0. ptr=3, so a later req=4'b0101 grants 0, because the search from 3 wraps to 0 before reaching 2.
- Wrap: owner 3 releases while req=4'b0011 -> next gnt=4'b0001.
- Mid-grant reset: rst_n=0 for one cycle while gnt=4'b0100 -> gnt=0 at that edge. With req=4'b0110 afterwards, the first grant is gnt=4'b0010 (ptr back to 0).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req[0] held forever, req[1] raised at cycle 2 -> gnt=4'b0001 for exactly 8 cycles, then gnt=4'b0010 with preempt=1 for one cycle. Without the macro, gnt stays 4'b0001 indefinitely.
